// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per clock.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, flush       : request pulse (sampled in IDLE), synchronous abort
//   funct3             : RV32M operation select
//   operand_a/b        : rs1 / rs2 values
//   busy, done, result : in-progress flag, completion pulse, registered result
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   acc_hi_q, acc_hi_d;   // product high half / partial remainder
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;   // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0]   mcand_q, mcand_d;     // multiplicand or divisor magnitude
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   rem_low, div_diff, fin_res;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_raw, prod_fix;

  // Operand decode: signedness, magnitudes and special divide cases.
  always_comb begin
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = sgn_a & operand_a[XLEN-1];
    b_neg    = sgn_b & operand_b[XLEN-1];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
    div_zero = funct3[2] && (operand_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (operand_a == INT_MIN) && (operand_b == '1);
  end

  // Iteration datapath and final sign correction / output select.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    // The shifted remainder is XLEN+1 bits; its top bit alone guarantees a fit.
    rem_low  = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
    div_ge   = acc_hi_q[XLEN-1] | (rem_low >= mcand_q);
    div_diff = rem_low - mcand_q;
    prod_raw = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    case (op_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = neg_q ? -acc_lo_q : acc_lo_q;
      default:                fin_res = neg_q ? -acc_hi_q : acc_hi_q;
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d   = funct3;
          cnt_d  = '0;
          busy_d = 1'b1;
          // REM follows the dividend sign; everything else the sign product.
          neg_d  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            state_d  = S_FINISH;
            acc_lo_d = '1;
            acc_hi_d = operand_a;
            neg_d    = 1'b0;
          end else if (div_ovf) begin
            state_d  = S_FINISH;
            acc_lo_d = INT_MIN;
            acc_hi_d = '0;
            neg_d    = 1'b0;
          end else begin
            state_d  = S_CALC;
            acc_hi_d = '0;
            acc_lo_d = funct3[2] ? a_mag : b_mag;
            mcand_d  = funct3[2] ? b_mag : a_mag;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_FINISH;
          end
          if (op_q[2]) begin
            acc_hi_d = div_ge ? div_diff : rem_low;
            acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
          end else if (acc_lo_q[0]) begin
            acc_hi_d = mul_sum[XLEN:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
          end else begin
            acc_hi_d = {1'b0, acc_hi_q[XLEN-1:1]};
            acc_lo_d = {acc_hi_q[0], acc_lo_q[XLEN-1:1]};
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (!flush) begin
          result_d = fin_res;
          done_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand_a = 32'h0;
  logic [31:0] operand_b = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res = 32'h0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'b000: begin p = 64'(ua * ub); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Transaction-level model of the handshake: countdown to done per accepted op.
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_result <= 32'h0;
    end else if (m_left != 0) begin
      if (flush) begin
        m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_result <= m_pend;
        end else begin
          m_done <= 1'b0;
        end
      end
    end else begin
      m_done <= 1'b0;
      if (start && !flush) begin
        m_left <= ref_lat(funct3, operand_a, operand_b);
        m_pend <= ref_op(funct3, operand_a, operand_b);
        m_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("busy", {31'h0, busy}, {31'h0, m_busy});
    chk("done", {31'h0, done}, {31'h0, m_done});
    chk("result", result, m_result);
  end

  // Issue one op (start in this cycle), wait bounded for done, check value and timing.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit poke);
    int n, busy_n;
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    busy_n = busy ? 1 : 0;
    n = 0;
    while (!done && n < 40) begin
      if (poke && n == 5) begin
        start = 1'b1; funct3 = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!done && busy) busy_n++;
    end
    start = 1'b0;
    chk("model_pin", ref_op(f, a, b), exp);
    chk("op_result", result, exp);
    chk("latency", 32'(n), 32'(exp_lat));
    if (exp_lat == 33) chk("busy_cycles", 32'(busy_n), 32'd33);
    if (done) last_res = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-computed results; consecutive calls are back-to-back.
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

    // Flush at iteration 10 of a DIV: busy drops, no done, result held.
    start = 1'b1; funct3 = 3'b100; operand_a = 32'd1000; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_done", {31'h0, done}, 32'h0);
    chk("flush_result", result, last_res);
    repeat (40) @(posedge clk);
    #1;
    run_op(3'b100, 32'd1000, 32'd3, 32'd333, 33, 1'b0);

    // Flush together with start in IDLE drops the request.
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; funct3 = 3'b011; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_result", result, 32'h0);
    last_res = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized ops, with divide corner operands mixed in.
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(f, a, b, ref_op(f, a, b), ref_lat(f, a, b), i[0]);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
